render_fb_writer: RTL and testbench
===================================

Name: render_fb_writer

Overview:
- Sits directly downstream of the full ray-tracing renderer. Consumes its AXI-stream pixel output: 24-bit RGB plus the hcount/vcount sideband that travels with each pixel.
- Packs each pixel to RGB565, computes the linear frame-buffer address, and issues valid/ready-handshaked writes to the frame-buffer BRAM write port.
- Tracks frame alignment with a small state machine and reports frame completion.
- Fully back-pressurable: stalls upstream via pixel_axis_tready when the BRAM port is busy.

Parameters:
- H_ACTIVE, 320, rendered frame width in pixels; hcount values >= H_ACTIVE are out of range.
- V_ACTIVE, 180, rendered frame height in lines; vcount values >= V_ACTIVE are out of range.
- ADDR_W, 16, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- aclk  in  1  sole clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- pixel_axis_tdata  in  24  pixel colour as {R[23:16], G[15:8], B[7:0]}.
- pixel_axis_tvalid  in  1  pixel, hcount_in and vcount_in are valid.
- pixel_axis_tready  out  1  block accepts the pixel this cycle.
- hcount_in  in  11  pixel column; qualified by pixel_axis_tvalid.
- vcount_in  in  10  pixel row; qualified by pixel_axis_tvalid.
- fb_waddr  out  ADDR_W  frame-buffer write address.
- fb_wdata  out  16  RGB565 write data.
- fb_wvalid  out  1  write request.
- fb_wready  in  1  BRAM port accepts the write.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted by the BRAM port.
- frame_count  out  16  completed-frame counter.
- drop_count  out  16  count of accepted but discarded pixels.

Behaviour:
- Reset: asynchronous, active-high, takes effect immediately.
  - All outputs go to 0, except pixel_axis_tready, which is 0 while areset is high and 1 on the first cycle after release.
  - State returns to SYNC and both pipeline stages are emptied. A write in flight is abandoned, not completed.
- Pipeline: two register stages, S1 then S2.
  - Global advance: adv = ~fb_wvalid | fb_wready.
  - pixel_axis_tready = adv.
  - S1 loads on adv with an accepted pixel, or a bubble when tvalid=0.
  - S2 loads from S1 on adv.
  - S2 drives fb_waddr, fb_wdata and fb_wvalid.
- Latency: a pixel accepted in cycle N appears on fb_w* in cycle N+2 when fb_wready stays high. Throughput is 1 pixel/cycle.
- Stall: while fb_wvalid=1 and fb_wready=0, all stages and outputs hold stable and tready=0. No data changes on the BRAM interface before the handshake completes.
- S1 computes:
  - rgb565 = {R[7:3], G[7:2], B[7:3]}.
  - row_base = vcount_in * H_ACTIVE, registered as an unsigned product truncated to ADDR_W.
  - in_range = (hcount_in < H_ACTIVE) && (vcount_in < V_ACTIVE).
  - is_first = (h==0 && v==0).
  - is_last = (h==H_ACTIVE-1 && v==V_ACTIVE-1).
- S2 computes fb_waddr = row_base + hcount (ADDR_W bits; no wrap is possible for in-range pixels).
- States:
  - SYNC (reset state). Every accepted pixel is discarded except a pixel with is_first=1. That pixel is written and moves the FSM to ACTIVE.
  - ACTIVE. Every in-range pixel is written. When the write with is_last=1 completes (fb_wvalid & fb_wready), frame_done pulses for 1 cycle, frame_count increments, and the FSM stays in ACTIVE.
- Discard rules:
  - Out-of-range pixels are discarded in both states.
  - A discarded pixel is still consumed (it is handshaked upstream), never produces fb_wvalid, and increments drop_count once.
  - drop_count saturates at 0xFFFF.
- frame_count wraps modulo 2^16.
- Simultaneous events:
  - A new pixel is accepted in the same cycle that S2 completes a write; no bubble is inserted.
  - frame_done may coincide with acceptance of the next frame's first pixel.
- The FSM decides state on the S1 stage. A SYNC→ACTIVE transition and the acceptance of a pixel in the next cycle are both handled correctly.

Test Plan:
- Reset release, then stream a 320x180 raster, 57600 pixels, h/v incrementing, tdata=0xFF8040, fb_wready=1.
  - Expect 57600 writes, addr 0..57599 in order, fb_wdata=0xFC08.
  - First write 2 cycles after first accept; frame_done once; frame_count=1; drop_count=0.
- After reset, feed pixels (5,0),(6,0), then (0,0),(1,0).
  - Expect the first two dropped (drop_count=2), with no fb_wvalid for them.
  - Then writes to addr 0 and 1.
- Backpressure: hold fb_wready=0 for 7 cycles during a write to addr 1000.
  - Expect fb_waddr/fb_wdata/fb_wvalid stable and tready=0 for those cycles.
  - No pixel lost or duplicated after release.
- In ACTIVE, send hcount=400,v=10 and then hcount=3,v=200.
  - Expect both dropped, drop_count +2, no writes.
  - Adjacent valid pixels are written with the correct addresses (v*320+h).
- Assert areset for 1 cycle while fb_wvalid=1 and fb_wready=0.
  - Expect all outputs 0 immediately and state back in SYNC.
  - The next (0,0) pixel is written to addr 0.
- Last pixel (319,179) completes in the same cycle that the next frame's (0,0) is accepted.
  - Expect frame_done pulse of exactly 1 cycle, frame_count=2.
  - The (0,0) write follows in the next cycle.

Source files
------------

// File: rtl/render_fb_writer_if.sv
// Pixel stream (with raster sideband) into the frame-buffer writer and its BRAM write port.
interface render_fb_writer_if #(
  parameter int ADDR_W = 16
);
  logic [23:0]       pixel_axis_tdata;
  logic              pixel_axis_tvalid;
  logic              pixel_axis_tready;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [ADDR_W-1:0] fb_waddr;
  logic [15:0]       fb_wdata;
  logic              fb_wvalid;
  logic              fb_wready;

  modport master (
    output pixel_axis_tdata, pixel_axis_tvalid, hcount_in, vcount_in, fb_wready,
    input  pixel_axis_tready, fb_waddr, fb_wdata, fb_wvalid
  );

  modport slave (
    input  pixel_axis_tdata, pixel_axis_tvalid, hcount_in, vcount_in, fb_wready,
    output pixel_axis_tready, fb_waddr, fb_wdata, fb_wvalid
  );
endinterface

// File: rtl/render_fb_writer.sv
// Packs rendered pixels to RGB565 and writes them to the frame buffer through a
// two-stage back-pressurable pipeline, locking onto frame start before writing.
module render_fb_writer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 180,
  parameter int ADDR_W   = 16
) (
  input  logic              aclk,
  input  logic              areset,
  render_fb_writer_if.slave bus,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count
);
  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t            state, state_nxt;
  logic              adv, wr_done, keep_p1, drop_p1;
  logic              vld_p1, in_range_p1, first_p1, last_p1;
  logic [15:0]       rgb_p1;
  logic [ADDR_W-1:0] row_base_p1;
  logic [10:0]       hcount_p1;
  logic              vld_p2, last_p2;
  logic [ADDR_W-1:0] waddr_p2;
  logic [15:0]       wdata_p2;
  logic              unused_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Low colour bits are dropped by the RGB565 truncation.
  assign unused_bits = ^{bus.pixel_axis_tdata[18:16], bus.pixel_axis_tdata[9:8],
                         bus.pixel_axis_tdata[2:0]};

  assign adv                   = ~vld_p2 | bus.fb_wready;
  assign wr_done               = vld_p2 & bus.fb_wready;
  assign bus.pixel_axis_tready = adv & ~areset;
  assign bus.fb_wvalid         = vld_p2;
  assign bus.fb_waddr          = waddr_p2;
  assign bus.fb_wdata          = wdata_p2;

  always_comb begin
    state_nxt = state;
    keep_p1   = 1'b0;
    drop_p1   = 1'b0;
    if (vld_p1) begin
      if (in_range_p1 && (state == ACTIVE || first_p1)) keep_p1 = 1'b1;
      else                                              drop_p1 = 1'b1;
    end
    if (adv && keep_p1 && state == SYNC) state_nxt = ACTIVE;
  end

  // S1: capture pixel, pack colour, precompute row base and raster flags
  always_ff @(posedge aclk) begin
    if (adv) begin
      rgb_p1      <= {bus.pixel_axis_tdata[23:19], bus.pixel_axis_tdata[15:10],
                      bus.pixel_axis_tdata[7:3]};
      row_base_p1 <= ADDR_W'(32'(bus.vcount_in) * 32'(H_ACTIVE));
      hcount_p1   <= bus.hcount_in;
      in_range_p1 <= (bus.hcount_in < H_LIM) && (bus.vcount_in < V_LIM);
      first_p1    <= (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
      last_p1     <= (bus.hcount_in == H_LAST) && (bus.vcount_in == V_LAST);
    end
  end

  // S2: write request to the frame buffer; also frame/drop bookkeeping
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= SYNC;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      last_p2     <= 1'b0;
      waddr_p2    <= '0;
      wdata_p2    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= wr_done & last_p2;
      if (wr_done && last_p2) frame_count <= frame_count + 16'd1;
      if (adv) begin
        vld_p1   <= bus.pixel_axis_tvalid;
        vld_p2   <= keep_p1;
        last_p2  <= last_p1;
        waddr_p2 <= row_base_p1 + ADDR_W'(hcount_p1);
        wdata_p2 <= rgb_p1;
        if (drop_p1) drop_count <= sat_inc(drop_count);
      end
    end
  end
endmodule

// File: tb/tb_render_fb_writer.sv
// Scoreboard bench for render_fb_writer: stimulus pushes expected writes from a raster-level
// model; a negedge monitor pops and compares every completed frame-buffer write.
module tb_render_fb_writer;
  logic        aclk = 1'b0;
  logic        areset;
  logic        frame_done;
  logic [15:0] frame_count, drop_count;

  render_fb_writer_if #(.ADDR_W(16)) bus ();

  render_fb_writer #(.H_ACTIVE(320), .V_ACTIVE(180), .ADDR_W(16)) dut (
    .aclk(aclk), .areset(areset), .bus(bus),
    .frame_done(frame_done), .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int addr;
    int data;
    bit last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0, n_total = 0;
  int          cyc = 0;
  bit          model_sync = 1'b1;
  int          exp_drop = 0, exp_frames = 0;
  int          wr_mode = 0, stall_left = 0, stall_seen = 0, fd_pulses = 0;
  int          lat_arm = 0, acc_cyc = 0, last_acc_cyc = 0, last_hs_cyc = -1;
  bit          prev_stall = 1'b0, exp_fd = 1'b0;
  logic [15:0] prev_addr = '0, prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Raster-level reference: decides write/drop per accepted pixel, in order.
  function automatic void model(input int h, input int v, input int c);
    exp_t e;
    bit inr   = (h < 320) && (v < 180);
    bit first = (h == 0) && (v == 0);
    bit last  = (h == 319) && (v == 179);
    if (inr && (!model_sync || first)) begin
      e.addr = v * 320 + h;
      e.data = (((c / 65536) % 256) / 8) * 2048 + (((c / 256) % 256) / 4) * 32 + ((c % 256) / 8);
      e.last = last;
      exp_q.push_back(e);
      if (first) model_sync = 1'b0;
      if (last) exp_frames++;
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    case (wr_mode)
      0: bus.fb_wready = 1'b1;
      1: bus.fb_wready = ($urandom_range(0, 3) != 0);
      2: if (bus.fb_wvalid && bus.fb_waddr == 16'd1000 && stall_left > 0) begin
           bus.fb_wready = 1'b0;
           stall_left--;
         end else begin
           bus.fb_wready = 1'b1;
         end
      default: bus.fb_wready = 1'b0;
    endcase
  end

  always @(negedge aclk) begin
    exp_t e;
    if (areset) begin
      prev_stall = 1'b0;
      exp_fd     = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) fd_pulses++;
      chk("tready", 32'(bus.pixel_axis_tready), 32'(!(bus.fb_wvalid && !bus.fb_wready)));
      if (prev_stall)
        chk("stall_hold", {15'd0, bus.fb_wvalid, bus.fb_waddr}, {15'd0, 1'b1, prev_addr});
      if (prev_stall) chk("stall_hold_data", 32'(bus.fb_wdata), 32'(prev_data));
      if (lat_arm == 2 && bus.fb_wvalid) begin
        chk("first_latency", 32'(cyc - acc_cyc), 32'd2);
        lat_arm = 0;
      end
      exp_fd = 1'b0;
      if (bus.fb_wvalid && bus.fb_wready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(bus.fb_waddr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", 32'(bus.fb_waddr), 32'(e.addr));
          chk("wdata", 32'(bus.fb_wdata), 32'(e.data));
          exp_fd = e.last;
          if (e.last) last_hs_cyc = cyc;
        end
      end
      prev_stall = bus.fb_wvalid && !bus.fb_wready;
      prev_addr  = bus.fb_waddr;
      prev_data  = bus.fb_wdata;
      if (prev_stall && bus.fb_waddr == 16'd1000) stall_seen++;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.pixel_axis_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int h, input int v, input logic [23:0] rgb);
    bit acc = 1'b0;
    bus.hcount_in         = 11'(h);
    bus.vcount_in         = 10'(v);
    bus.pixel_axis_tdata  = rgb;
    bus.pixel_axis_tvalid = 1'b1;
    for (int i = 0; i < 1000 && !acc; i++) begin
      @(negedge aclk);
      if (bus.pixel_axis_tready) begin
        acc = 1'b1;
        model(h, v, int'(rgb));
        if (lat_arm == 1) begin
          acc_cyc = cyc;
          lat_arm = 2;
        end
        last_acc_cyc = cyc;
      end
      tick();
    end
    bus.pixel_axis_tvalid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    if (wr_mode != 2) wr_mode = 0;
    idle(4);
    for (int i = 0; i < 300 && !ok; i++) begin
      if (exp_q.size() == 0 && !bus.fb_wvalid) ok = 1'b1;
      else tick();
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int fd0, d0, a00;
    areset                = 1'b1;
    bus.pixel_axis_tvalid = 1'b0;
    bus.pixel_axis_tdata  = '0;
    bus.hcount_in         = '0;
    bus.vcount_in         = '0;
    bus.fb_wready         = 1'b1;
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_tready", 32'(bus.pixel_axis_tready), 32'd0);
    chk("rst_wvalid", 32'(bus.fb_wvalid), 32'd0);
    chk("rst_waddr", 32'(bus.fb_waddr), 32'd0);
    chk("rst_counts", {frame_count, drop_count}, 32'd0);
    tick();
    areset = 1'b0;
    @(negedge aclk);
    chk("tready_after_release", 32'(bus.pixel_axis_tready), 32'd1);
    tick();

    // Full raster at full rate.
    fd0     = fd_pulses;
    lat_arm = 1;
    for (int v = 0; v < 180; v++)
      for (int h = 0; h < 320; h++) send(h, v, 24'hFF8040);
    drain();
    chk("raster_frame_count", 32'(frame_count), 32'd1);
    chk("raster_drop_count", 32'(drop_count), 32'd0);
    chk("raster_done_pulses", 32'(fd_pulses - fd0), 32'd1);

    // Seven-cycle stall on the write to address 1000.
    wr_mode    = 2;
    stall_left = 7;
    stall_seen = 0;
    for (int h = 36; h < 46; h++) send(h, 3, 24'($urandom));
    drain();
    chk("stall_cycles", 32'(stall_seen), 32'd7);
    wr_mode = 0;

    // Out-of-range pixels between valid ones.
    d0 = exp_drop;
    send(8, 10, 24'h123456);
    send(400, 10, 24'hABCDEF);
    send(3, 200, 24'h00FF00);
    send(9, 10, 24'h654321);
    drain();
    chk("oor_drops", 32'(drop_count), 32'(d0 + 2));

    // Frame end coinciding with the next frame's first accept.
    fd0 = fd_pulses;
    send(318, 179, 24'h808080);
    send(319, 179, 24'hFFFFFF);
    idle(1);
    send(0, 0, 24'h0000FF);
    a00 = last_acc_cyc;
    send(1, 0, 24'hFF0000);
    drain();
    chk("wrap_frame_count", 32'(frame_count), 32'd2);
    chk("wrap_done_pulses", 32'(fd_pulses - fd0), 32'd1);
    chk("wrap_coincide", 32'(a00), 32'(last_hs_cyc));

    // Random pixels, including out-of-range, with random backpressure.
    wr_mode = 1;
    repeat (1500) begin
      send($urandom_range(0, 340), $urandom_range(0, 190), 24'($urandom));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();
    chk("rand_drop_count", 32'(drop_count), 32'(exp_drop));
    chk("rand_frame_count", 32'(frame_count), 32'(exp_frames));

    // Reset while a write is stalled.
    wr_mode = 3;
    send(7, 7, 24'h777777);
    for (int i = 0; i < 10 && !bus.fb_wvalid; i++) tick();
    chk("stalled_write_present", 32'(bus.fb_wvalid), 32'd1);
    areset = 1'b1;
    #1;
    chk("areset_wvalid", 32'(bus.fb_wvalid), 32'd0);
    chk("areset_waddr_wdata", {bus.fb_waddr, bus.fb_wdata}, 32'd0);
    chk("areset_tready", 32'(bus.pixel_axis_tready), 32'd0);
    chk("areset_counts", {frame_count, drop_count}, 32'd0);
    chk("areset_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    model_sync = 1'b1;
    exp_drop   = 0;
    exp_frames = 0;
    wr_mode    = 0;
    tick();
    areset = 1'b0;
    tick();

    // Re-synchronisation: pixels before (0,0) are dropped.
    send(5, 0, 24'h112233);
    send(6, 0, 24'h445566);
    send(0, 0, 24'hFF8040);
    send(1, 0, 24'h8040FF);
    drain();
    chk("sync_drop_count", 32'(drop_count), 32'd2);
    chk("sync_frame_count", 32'(frame_count), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
